// File: rtl/mmm_pkg.sv
// Shared memory-subsystem definitions: cache geometry and the icache refill FSM
// state type.
package mmm_pkg;

  localparam int XLEN            = 64;
  localparam int ICACHE_LINE_LEN = 1024;
  localparam int ICACHE_BEAT_LEN = 128;
  localparam int ICACHE_BEATS    = ICACHE_LINE_LEN / ICACHE_BEAT_LEN;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    REFILL,
    WRITE,
    DRAIN
  } refill_state_t;

  // Beat counter width; a single-beat line still needs a 1-bit counter.
  function automatic int cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/icache_line_buf.sv
// Refill line assembly buffer: beat counter plus one register slice per beat,
// written in arrival order.
module icache_line_buf #(
  parameter int LINE_LEN = 1024,
  parameter int BEAT_LEN = 128,
  parameter int CNT_W    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                beat_we,
  input  logic [BEAT_LEN-1:0] beat_data,
  output logic [CNT_W-1:0]    cnt,
  output logic                last,
  output logic [LINE_LEN-1:0] line
);

  localparam int BEATS = LINE_LEN / BEAT_LEN;

  logic [CNT_W-1:0] cnt_reg;

  assign cnt  = cnt_reg;
  assign last = (cnt_reg == CNT_W'(BEATS - 1));

  // Counter wraps to 0 after the last beat so the next refill starts clean.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt_reg <= '0;
    end else if (beat_we) begin
      cnt_reg <= last ? '0 : cnt_reg + CNT_W'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_beat
      logic [BEAT_LEN-1:0] slice_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          slice_reg <= '0;
        end else if (beat_we && (cnt_reg == CNT_W'(gi))) begin
          slice_reg <= beat_data;
        end
      end

      assign line[gi*BEAT_LEN +: BEAT_LEN] = slice_reg;
    end
  endgenerate

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction cache miss/refill controller. Optional performance counters are
// enabled with the ICACHE_REFILL_PERF_EN macro.
module icache_refill_ctrl
  import mmm_pkg::*;
#(
  parameter int LINE_LEN = ICACHE_LINE_LEN,
  parameter int BEAT_LEN = ICACHE_BEAT_LEN,
  parameter int ADDR_LEN = XLEN
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                miss_i,
  input  logic [ADDR_LEN-1:0] miss_addr_i,
  input  logic                flush_i,
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic [ADDR_LEN-1:0] mem_req_addr_o,
  input  logic                mem_rsp_valid_i,
  input  logic [BEAT_LEN-1:0] mem_rsp_data_i,
  output logic                mem_rsp_ready_o,
  output logic                wr_en_o,
  output logic [ADDR_LEN-1:0] wr_addr_o,
  output logic [LINE_LEN-1:0] wr_line_o,
  output logic                stall_o,
  output logic                refill_done_o
`ifdef ICACHE_REFILL_PERF_EN
  ,
  output logic [31:0]         miss_cnt_o,
  output logic [31:0]         stall_cnt_o
`endif
);

  localparam int BEATS = LINE_LEN / BEAT_LEN;
  localparam int OFS   = $clog2(LINE_LEN / 8);
  localparam int CNT_W = cnt_width(BEATS);
  localparam logic [ADDR_LEN-1:0] LINE_MASK = {{(ADDR_LEN-OFS){1'b1}}, {OFS{1'b0}}};

  refill_state_t       state_reg, state_next;
  logic                flush_seen_reg, flush_seen_next;
  logic [ADDR_LEN-1:0] addr_reg;
  logic [CNT_W-1:0]    beat_cnt;
  logic                beat_last;
  logic                beat_accept;
  logic                start;

  assign start       = (state_reg == IDLE) && miss_i && !flush_i;
  assign beat_accept = mem_rsp_valid_i && mem_rsp_ready_o;

  icache_line_buf #(
    .LINE_LEN (LINE_LEN),
    .BEAT_LEN (BEAT_LEN),
    .CNT_W    (CNT_W)
  ) u_line_buf (
    .clk       (clk_i),
    .rst_n     (rst_n_i),
    .clear     (start),
    .beat_we   (beat_accept),
    .beat_data (mem_rsp_data_i),
    .cnt       (beat_cnt),
    .last      (beat_last),
    .line      (wr_line_o)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_reg      <= IDLE;
      flush_seen_reg <= 1'b0;
      addr_reg       <= '0;
    end else begin
      state_reg      <= state_next;
      flush_seen_reg <= flush_seen_next;
      if (start) begin
        addr_reg <= miss_addr_i & LINE_MASK;
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    flush_seen_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = REQ;
      end
      REQ: begin
        // A redirect anywhere in the request phase still lets the request
        // complete; the response is then drained rather than written.
        flush_seen_next = flush_seen_reg || flush_i;
        if (mem_req_ready_i) begin
          state_next      = (flush_seen_reg || flush_i) ? DRAIN : REFILL;
          flush_seen_next = 1'b0;
        end
      end
      REFILL: begin
        if (beat_accept && beat_last) begin
          state_next = flush_i ? IDLE : WRITE;
        end else if (flush_i) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (beat_accept && beat_last) state_next = IDLE;
      end
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_req_valid_o = 1'b0;
    mem_rsp_ready_o = 1'b0;
    wr_en_o         = 1'b0;
    refill_done_o   = 1'b0;
    stall_o         = (state_reg != IDLE);
    case (state_reg)
      REQ:           mem_req_valid_o = 1'b1;
      REFILL, DRAIN: mem_rsp_ready_o = 1'b1;
      WRITE: begin
        wr_en_o       = 1'b1;
        refill_done_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_req_addr_o = addr_reg;
  assign wr_addr_o      = addr_reg;

`ifdef ICACHE_REFILL_PERF_EN
  logic [31:0] miss_cnt_reg, stall_cnt_reg;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      miss_cnt_reg  <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (start && (miss_cnt_reg != '1)) miss_cnt_reg <= miss_cnt_reg + 32'd1;
      if (stall_o && (stall_cnt_reg != '1)) stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign miss_cnt_o  = miss_cnt_reg;
  assign stall_cnt_o = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed-plus-random bench for icache_refill_ctrl; expected lines and
// addresses come from a line-level model of each refill transaction.
module tb_icache_refill_ctrl;

  localparam int LINE_LEN = 1024;
  localparam int BEAT_LEN = 128;
  localparam int ADDR_LEN = 64;
  localparam int BEATS    = LINE_LEN / BEAT_LEN;
  localparam int LINE_BYTES = LINE_LEN / 8;

  logic                clk_i = 1'b0;
  logic                rst_n_i = 1'b0;
  logic                miss_i = 1'b0;
  logic [ADDR_LEN-1:0] miss_addr_i = '0;
  logic                flush_i = 1'b0;
  logic                mem_req_valid_o;
  logic                mem_req_ready_i = 1'b0;
  logic [ADDR_LEN-1:0] mem_req_addr_o;
  logic                mem_rsp_valid_i = 1'b0;
  logic [BEAT_LEN-1:0] mem_rsp_data_i = '0;
  logic                mem_rsp_ready_o;
  logic                wr_en_o;
  logic [ADDR_LEN-1:0] wr_addr_o;
  logic [LINE_LEN-1:0] wr_line_o;
  logic                stall_o;
  logic                refill_done_o;
`ifdef ICACHE_REFILL_PERF_EN
  logic [31:0]         miss_cnt_o;
  logic [31:0]         stall_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  icache_refill_ctrl dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .miss_i          (miss_i),
    .miss_addr_i     (miss_addr_i),
    .flush_i         (flush_i),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_data_i  (mem_rsp_data_i),
    .mem_rsp_ready_o (mem_rsp_ready_o),
    .wr_en_o         (wr_en_o),
    .wr_addr_o       (wr_addr_o),
    .wr_line_o       (wr_line_o),
    .stall_o         (stall_o),
    .refill_done_o   (refill_done_o)
`ifdef ICACHE_REFILL_PERF_EN
    ,
    .miss_cnt_o      (miss_cnt_o),
    .stall_cnt_o     (stall_cnt_o)
`endif
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_line(input string tag, input logic [LINE_LEN-1:0] obs, input logic [LINE_LEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [BEAT_LEN-1:0] rand_beat();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One complete miss, entered and left at a negedge with the DUT idle.
  // flush_mode: 0 none, 1 redirect during the request phase,
  // 2 redirect in the cycle after beat flush_after is accepted.
  task automatic run_miss(input logic [ADDR_LEN-1:0] addr, input int req_wait,
                          input int valid_pct, input int flush_mode,
                          input int flush_after, input bit idx_data);
    logic [ADDR_LEN-1:0] exp_addr;
    logic [LINE_LEN-1:0] exp_line;
    int  got, cyc;
    bit  v, flushed, drop;
    exp_addr = (addr / LINE_BYTES) * LINE_BYTES;
    exp_line = '0;
    drop     = (flush_mode != 0);
    chk1("idle_stall", stall_o, 1'b0);
    miss_i      = 1'b1;
    miss_addr_i = addr;
    @(negedge clk_i);
    miss_i      = 1'b0;
    miss_addr_i = {$urandom(), $urandom()};
    chk1("req_valid", mem_req_valid_o, 1'b1);
    chk64("req_addr", mem_req_addr_o, exp_addr);
    chk1("req_stall", stall_o, 1'b1);
    for (int w = 0; w <= req_wait; w++) begin
      if (w > 0) begin
        chk1("req_hold_valid", mem_req_valid_o, 1'b1);
        chk64("req_hold_addr", mem_req_addr_o, exp_addr);
      end
      chk1("req_no_rsp_ready", mem_rsp_ready_o, 1'b0);
      mem_req_ready_i = (w == req_wait);
      mem_rsp_valid_i = (w != req_wait);
      mem_rsp_data_i  = rand_beat();
      flush_i         = (flush_mode == 1) && (w == 0);
      @(negedge clk_i);
    end
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    flush_i         = 1'b0;
    chk1("req_single", mem_req_valid_o, 1'b0);
    got = 0; cyc = 0; flushed = 1'b0;
    while (got < BEATS && cyc < 200) begin
      chk1("rsp_ready", mem_rsp_ready_o, 1'b1);
      chk1("no_early_wr", wr_en_o, 1'b0);
      v = idx_data ? 1'b1 : ($urandom_range(99) < valid_pct);
      mem_rsp_valid_i = v;
      mem_rsp_data_i  = idx_data ? BEAT_LEN'(got) : rand_beat();
      flush_i = (flush_mode == 2) && !flushed && (got == flush_after + 1);
      if (flush_i) flushed = 1'b1;
      @(negedge clk_i);
      if (v) begin
        exp_line[got*BEAT_LEN +: BEAT_LEN] = mem_rsp_data_i;
        got++;
      end
      cyc++;
    end
    mem_rsp_valid_i = 1'b0;
    flush_i         = 1'b0;
    chk1("beat_budget", got == BEATS, 1'b1);
    if (!drop) begin
      chk1("wr_en", wr_en_o, 1'b1);
      chk1("refill_done", refill_done_o, 1'b1);
      chk64("wr_addr", wr_addr_o, exp_addr);
      chk_line("wr_line", wr_line_o, exp_line);
      chk1("wr_stall", stall_o, 1'b1);
      @(negedge clk_i);
      chk1("wr_once", wr_en_o, 1'b0);
      chk1("release", stall_o, 1'b0);
    end else begin
      chk1("drop_no_wr", wr_en_o, 1'b0);
      chk1("drop_no_done", refill_done_o, 1'b0);
      chk1("drop_release", stall_o, 1'b0);
    end
    $display("txn addr=%h wait=%0d valid_pct=%0d flush_mode=%0d beat_cycles=%0d checks=%0d errors=%0d",
             addr, req_wait, valid_pct, flush_mode, cyc, checks, errors);
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    chk1("rst_req_valid", mem_req_valid_o, 1'b0);
    chk1("rst_rsp_ready", mem_rsp_ready_o, 1'b0);
    chk1("rst_wr_en", wr_en_o, 1'b0);
    chk1("rst_done", refill_done_o, 1'b0);
    chk1("rst_stall", stall_o, 1'b0);
    chk64("rst_req_addr", mem_req_addr_o, 64'd0);
    chk_line("rst_line", wr_line_o, '0);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    run_miss(64'h0000_0000_1234_5678, 0, 100, 0, 0, 1'b1);
    run_miss({$urandom(), $urandom()}, 5, 100, 0, 0, 1'b0);
    run_miss({$urandom(), $urandom()}, 0, 100, 2, 3, 1'b0);

    // Redirect wins over a same-cycle miss.
    miss_i = 1'b1; flush_i = 1'b1; miss_addr_i = {$urandom(), $urandom()};
    @(negedge clk_i);
    miss_i = 1'b0; flush_i = 1'b0;
    chk1("flush_miss_no_req", mem_req_valid_o, 1'b0);
    chk1("flush_miss_no_stall", stall_o, 1'b0);
    $display("txn idle miss+flush checks=%0d errors=%0d", checks, errors);

    // Stray response beat while idle must be refused and not counted.
    mem_rsp_valid_i = 1'b1; mem_rsp_data_i = rand_beat();
    @(negedge clk_i);
    chk1("idle_rsp_refused", mem_rsp_ready_o, 1'b0);
    mem_rsp_valid_i = 1'b0;
    $display("txn idle stray beat checks=%0d errors=%0d", checks, errors);

    for (int i = 0; i < 3; i++) run_miss({$urandom(), $urandom()}, 2, 60, 0, 0, 1'b0);
    run_miss({$urandom(), $urandom()}, 3, 100, 1, 0, 1'b0);

    // Reset in the middle of a refill, after beat 2.
    miss_i = 1'b1; miss_addr_i = {$urandom(), $urandom()};
    @(negedge clk_i);
    miss_i = 1'b0; mem_req_ready_i = 1'b1;
    @(negedge clk_i);
    mem_req_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mem_rsp_valid_i = 1'b1; mem_rsp_data_i = rand_beat();
      @(negedge clk_i);
    end
    mem_rsp_valid_i = 1'b0;
    chk1("mid_refill_stall", stall_o, 1'b1);
    rst_n_i = 1'b0;
    @(negedge clk_i);
    chk1("mrst_req_valid", mem_req_valid_o, 1'b0);
    chk1("mrst_rsp_ready", mem_rsp_ready_o, 1'b0);
    chk1("mrst_wr_en", wr_en_o, 1'b0);
    chk1("mrst_done", refill_done_o, 1'b0);
    chk1("mrst_stall", stall_o, 1'b0);
    chk64("mrst_req_addr", mem_req_addr_o, 64'd0);
    chk_line("mrst_line", wr_line_o, '0);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    $display("txn reset mid-refill checks=%0d errors=%0d", checks, errors);
    run_miss({$urandom(), $urandom()}, 1, 100, 0, 0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      run_miss({$urandom(), $urandom()}, int'($urandom_range(4)),
               int'($urandom_range(100, 40)), int'($urandom_range(2)),
               int'($urandom_range(6)), 1'b0);
    end

`ifdef ICACHE_REFILL_PERF_EN
    rst_n_i = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    chk64("perf_rst_miss", {32'd0, miss_cnt_o}, 64'd0);
    chk64("perf_rst_stall", {32'd0, stall_cnt_o}, 64'd0);
    run_miss({$urandom(), $urandom()}, 0, 100, 0, 0, 1'b0);
    run_miss({$urandom(), $urandom()}, 0, 100, 0, 0, 1'b0);
    chk64("perf_miss_cnt", {32'd0, miss_cnt_o}, 64'd2);
    chk64("perf_stall_cnt", {32'd0, stall_cnt_o}, 64'(2 * (BEATS + 2)));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
